// File: rtl/demux_pkg.sv
// Shared types and defaults for the registered 1-to-2 demultiplexer.
package demux_pkg;

  localparam int DEMUX_WIDTH = 32;
  localparam int DEMUX_CNT_W = 16;

  // Occupancy of a one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  // A slot can take a new word when it is empty or is being drained this cycle.
  function automatic logic slot_can_load(input slot_e state, input logic drain);
    return (state == SLOT_EMPTY) || drain;
  endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry output buffer with a wrapping count of completed output handshakes.
import demux_pkg::*;

module out_slot #(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             can_load
);

  slot_e            state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  assign drain     = (state_q == SLOT_FULL) && out_ready;
  assign can_load  = slot_can_load(state_q, out_ready);
  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;

  // Next-state: flush empties the slot and freezes the counter; otherwise load wins over drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = SLOT_EMPTY;
    end else begin
      if (drain) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (load) begin
        state_d = SLOT_FULL;
        data_d  = load_data;
      end else if (drain) begin
        state_d = SLOT_EMPTY;
      end
    end
  end

  // Slot registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into port A (sel=1) or port B (sel=0).
import demux_pkg::*;

module demux_1x2_reg #(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] b_cnt
);

  logic a_can_load, b_can_load;
  logic a_load, b_load;
  logic sel_free;

  // Only the selected slot gates acceptance, so a stalled port never blocks the other.
  always_comb begin
    sel_free = in_sel ? a_can_load : b_can_load;
    in_ready = rst_n && !flush && sel_free;
    a_load   = in_valid && in_ready && in_sel;
    b_load   = in_valid && in_ready && !in_sel;
  end

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (a_load),
    .load_data (in_data),
    .out_ready (a_ready),
    .out_valid (a_valid),
    .out_data  (a_data),
    .out_cnt   (a_cnt),
    .can_load  (a_can_load)
  );

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (b_load),
    .load_data (in_data),
    .out_ready (b_ready),
    .out_valid (b_valid),
    .out_data  (b_data),
    .out_cnt   (b_cnt),
    .can_load  (b_can_load)
  );

endmodule

// File: doc/demux_1x2_reg.md
DEMUX_1X2_REG -- requirements
Module: demux_1x2_reg

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits.
REQ-002 Parameter: CNT_W, default 16, width of each per-port transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous clear of both output slots.
REQ-006 in_data  input  WIDTH  word to be steered.
REQ-007 in_sel  input  1  destination: 1 = port A, 0 = port B (same polarity as mux_2X1 Sel).
REQ-008 in_valid  input  1  in_data/in_sel valid.
REQ-009 in_ready  output  1  block accepts the word this cycle.
REQ-010 a_data / b_data  output  WIDTH  registered word at port A / port B.
REQ-011 a_valid / b_valid  output  1  port holds a word.
REQ-012 a_ready / b_ready  input  1  consumer takes the word this cycle.
REQ-013 a_cnt / b_cnt  output  CNT_W  count of completed output handshakes per port.

Function
REQ-014 Each port SHALL own one one-entry slot with states EMPTY and FULL; a_valid/b_valid SHALL equal (slot == FULL).
REQ-015 Input handshake SHALL occur when in_valid && in_ready; output handshake when x_valid && x_ready.
REQ-016 in_ready SHALL be combinational: !flush && (selected slot EMPTY || selected slot drained this cycle by x_ready).
REQ-017 Non-selected slot state SHALL NOT influence in_ready (no head-of-line blocking between ports).
REQ-018 On accepted input, word SHALL appear at selected port one cycle later with x_valid=1; latency exactly 1 cycle.
REQ-019 Slot transitions: EMPTY->FULL on load; FULL->EMPTY on drain without load; FULL->FULL with new data on simultaneous drain and load; otherwise hold.
REQ-020 x_data SHALL remain stable while x_valid=1 and x_ready=0.
REQ-021 Non-selected port SHALL be unaffected by an input handshake (data, valid unchanged).
REQ-022 x_cnt SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-023 flush=1 SHALL set both slots EMPTY next cycle, force in_ready=0, and suppress counter increments that cycle; flush has priority over all handshakes.
REQ-024 in_sel and in_data SHALL be ignored when in_valid=0; X on in_sel when in_valid=0 SHALL NOT propagate to in_ready beyond X-pessimism in simulation.
REQ-025 No data SHALL be duplicated or lost: every input handshake maps to exactly one output handshake unless flushed or reset.

Reset
REQ-026 rst_n low SHALL immediately set both slots EMPTY, a_valid=b_valid=0, a_cnt=b_cnt=0, a_data=b_data=0.
REQ-027 in_ready SHALL be 0 while rst_n is low.
REQ-028 Reset asserted mid-transfer SHALL discard held words; first cycle after release SHALL behave as empty block.

Structure
REQ-029 Slot state enum (EMPTY, FULL) and WIDTH/CNT_W defaults SHALL live in shared package demux_pkg.
REQ-030 One sub-module out_slot (one-entry buffer plus counter) SHALL be instantiated twice, for port A and port B.
REQ-031 Top level SHALL contain only steering of load enables and the in_ready equation.

Verification
REQ-032 Reset: rst_n=0 mid-stream with both slots FULL -> a_valid=b_valid=0, counters 0, in_ready=0 immediately.
REQ-033 Steering: send 0xDEADBEEF sel=1 then 0x12345678 sel=0, ready high -> A shows 0xDEADBEEF one cycle after accept, B shows 0x12345678 next cycle, a_cnt=b_cnt=1.
REQ-034 Backpressure: a_ready=0 with A FULL, input sel=1 -> in_ready=0, a_data stable; input sel=0 in same period -> accepted to B.
REQ-035 Simultaneous: A FULL holding 0x1, a_ready=1, new input 0x2 sel=1 -> in_ready=1, A holds 0x2 next cycle with a_valid=1, a_cnt+1.
REQ-036 Wrap: CNT_W=4, 17 handshakes on B -> b_cnt=1.
REQ-037 Flush: both slots FULL, flush=1 with in_valid=1 -> in_ready=0, both valid=0 next cycle, counters unchanged.
